servo_slew_ctrl: RTL and testbench



---
 rtl/servo_slew_ctrl.sv | 104 ++++++++++
 tb/tb_servo_slew_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_ctrl.sv
`timescale 1ns/1ps
// servo_slew_ctrl: clamps a handshaked servo duty target and ramps duty_cycle toward it once per PWM frame.
// Optional SERVO_IDLE_RELEASE_EN drops pwm_enable after IDLE_FRAMES idle frames.
module servo_slew_ctrl #(
   parameter int SYS_FREQ_MHZ = 25,
   parameter int FRAME_NS     = 20_000_000,
   parameter int DUTY_MIN     = 21,
   parameter int DUTY_MAX     = 102,
   parameter int DUTY_RESET   = 62,
   parameter int STEP         = 2,
   parameter int IDLE_FRAMES  = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       target_valid,
   output logic       target_ready,
   input  logic [9:0] target_duty,
   output logic [9:0] duty_cycle,
   output logic       frame_tick,
   output logic       busy,
   output logic       at_target,
   output logic       pwm_enable
);
   localparam int FRAME_CYCLES = FRAME_NS * SYS_FREQ_MHZ / 1000;
   localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
   typedef enum logic {IDLE, MOVING} state_t;
   logic [CW-1:0] cnt_q, cnt_d;
   logic tick_q, tick_d, pend_q, pend_d, rdy_q, rdy_d, busy_q, busy_d, at_q, at_d;
   logic [9:0] duty_q, duty_d, tgt_q, tgt_d, pv_q, pv_d, clamped, step;
   logic [10:0] diff;
   logic up, acc;
   state_t state_q, state_d;
   always_comb begin
      acc = target_valid && rdy_q;
      clamped = target_duty < 10'(DUTY_MIN) ? 10'(DUTY_MIN) : target_duty > 10'(DUTY_MAX) ? 10'(DUTY_MAX) : target_duty;
      cnt_d = cnt_q == LAST ? '0 : cnt_q + CW'(1);
      tick_d = cnt_d == LAST;
      up = tgt_q > duty_q;
      diff = up ? {1'b0, tgt_q} - {1'b0, duty_q} : {1'b0, duty_q} - {1'b0, tgt_q};
      step = diff > 11'(STEP) ? 10'(STEP) : diff[9:0];
      // step uses the old target; a pending target only becomes active at this same edge
      duty_d = !tick_q ? duty_q : up ? duty_q + step : duty_q - step;
      tgt_d = tick_q && pend_q ? pv_q : tgt_q;
      pv_d = acc ? clamped : pv_q;
      pend_d = acc || (pend_q && !tick_q);
      state_d = duty_d != tgt_d ? MOVING : IDLE;
      rdy_d = !pend_d;
      busy_d = state_d == MOVING;
      at_d = state_d == IDLE && !pend_d;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         duty_q  <= 10'(DUTY_RESET);
         tgt_q   <= 10'(DUTY_RESET);
         pv_q    <= 10'(DUTY_RESET);
         pend_q  <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         at_q    <= 1'b1;
         state_q <= IDLE;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         pv_q    <= pv_d;
         pend_q  <= pend_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         at_q    <= at_d;
         state_q <= state_d;
      end
   end
`ifdef SERVO_IDLE_RELEASE_EN
   localparam int IW = $clog2(IDLE_FRAMES + 1);
   logic [IW-1:0] idle_q, idle_d;
   logic en_q, en_d;
   always_comb begin
      idle_d = (acc || state_d == MOVING) ? '0 :
               (tick_q && state_q == IDLE && !pend_q && idle_q != IW'(IDLE_FRAMES)) ? idle_q + IW'(1) : idle_q;
      en_d = acc ? 1'b1 : idle_d == IW'(IDLE_FRAMES) ? 1'b0 : en_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idle_q <= '0;
         en_q   <= 1'b1;
      end else begin
         idle_q <= idle_d;
         en_q   <= en_d;
      end
   end
   assign pwm_enable = en_q;
`else
   assign pwm_enable = 1'b1;
`endif
   assign target_ready = rdy_q;
   assign duty_cycle   = duty_q;
   assign frame_tick   = tick_q;
   assign busy         = busy_q;
   assign at_target    = at_q;
endmodule

// File: tb/tb_servo_slew_ctrl.sv
`timescale 1ns/1ps
// tb_servo_slew_ctrl: directed stimulus for servo_slew_ctrl with a frame-level reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_servo_slew_ctrl;
   localparam int FC = 10;
   localparam int IF_N = 3;
   logic clk = 0, reset = 1, target_valid = 0;
   logic [9:0] target_duty = 0;
   logic target_ready, frame_tick, busy, at_target, pwm_enable;
   logic [9:0] duty_cycle;
   int total = 0, bad = 0;
   int m_cyc, m_duty, m_tgt, m_pv, m_idle;
   bit m_pend, m_en, m_tick, m_acc, m_was_idle;

   servo_slew_ctrl #(.SYS_FREQ_MHZ(25), .FRAME_NS(400), .IDLE_FRAMES(IF_N)) dut (
      .clk(clk), .reset(reset), .target_valid(target_valid), .target_ready(target_ready),
      .target_duty(target_duty), .duty_cycle(duty_cycle), .frame_tick(frame_tick),
      .busy(busy), .at_target(at_target), .pwm_enable(pwm_enable)
   );

   always #5 clk = ~clk;

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int approach(int d, int t);
      if (d < t) return d + ((t - d) < 2 ? (t - d) : 2);
      if (d > t) return d - ((d - t) < 2 ? (d - t) : 2);
      return d;
   endfunction

   function automatic int clampi(int v);
      return v < 21 ? 21 : v > 102 ? 102 : v;
   endfunction

   // frame-level reference: one update per clock, ramp step and target load only on tick edges
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cyc = 0; m_duty = 62; m_tgt = 62; m_pv = 62; m_pend = 0; m_en = 1; m_idle = 0;
      end else begin
         m_tick = (m_cyc % FC) == FC - 1;
         m_acc = target_valid && !m_pend;
         m_was_idle = m_duty == m_tgt && !m_pend;
         if (m_tick) begin
            m_duty = approach(m_duty, m_tgt);
            if (m_pend) begin m_tgt = m_pv; m_pend = 0; end
         end
         if (m_acc) begin m_pend = 1; m_pv = clampi(int'(target_duty)); end
         if (m_acc || m_duty != m_tgt) m_idle = 0;
         else if (m_tick && m_was_idle) m_idle++;
         m_en = m_acc ? 1 : (m_idle >= IF_N ? 0 : m_en);
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      check("duty_cycle", int'(duty_cycle), m_duty);
      check("target_ready", int'(target_ready), int'(!m_pend));
      check("busy", int'(busy), int'(m_duty != m_tgt));
      check("at_target", int'(at_target), int'(m_duty == m_tgt && !m_pend));
      check("frame_tick", int'(frame_tick), int'(reset && (m_cyc % FC) == FC - 1));
`ifdef SERVO_IDLE_RELEASE_EN
      check("pwm_enable", int'(pwm_enable), int'(m_en));
`else
      check("pwm_enable", int'(pwm_enable), 1);
`endif
   end

   task automatic send(int v);
      int n = 0;
      @(negedge clk);
      target_valid = 1;
      target_duty = 10'(v);
      while (!target_ready && n < 40) begin @(negedge clk); n++; end
      if (!target_ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1 target_valid = 0;
   endtask

   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (!frame_tick && n < 30) begin @(negedge clk); n++; end
      if (!frame_tick) check("tick_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      int n = 0;
      wait_tick();
      while (busy && n < 60) begin wait_tick(); n++; end
      if (busy) check("settle_timeout", 0, 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2 reset = 0;
      #1;
      check("rst_duty", int'(duty_cycle), 62);
      check("rst_ready", int'(target_ready), 1);
      #24 reset = 1;
      n = 0;
      repeat (40) begin @(negedge clk); if (frame_tick) n++; end
      check("tick_count_40", n, 4);
      check("idle_duty", int'(duty_cycle), 62);
      check("idle_at_target", int'(at_target), 1);
      check("idle_busy", int'(busy), 0);
      send(70);
      check("ready_low_after_accept", int'(target_ready), 0);
      wait_tick();
      check("load_busy", int'(busy), 1);
      check("load_duty", int'(duty_cycle), 62);
      wait_tick(); check("ramp_64", int'(duty_cycle), 64);
      wait_tick(); check("ramp_66", int'(duty_cycle), 66);
      wait_tick(); check("ramp_68", int'(duty_cycle), 68);
      wait_tick(); check("ramp_70", int'(duty_cycle), 70);
      check("ramp_70_busy", int'(busy), 0);
      check("ramp_70_at", int'(at_target), 1);
      send(5); settle();
      check("clamp_low", int'(duty_cycle), 21);
      send(1000); settle();
      check("clamp_high", int'(duty_cycle), 102);
      send(62); settle();
      send(65); wait_tick();
      wait_tick(); check("odd_up_64", int'(duty_cycle), 64);
      wait_tick(); check("odd_up_65", int'(duty_cycle), 65);
      check("odd_up_idle", int'(busy), 0);
      send(62); wait_tick();
      wait_tick(); check("odd_dn_63", int'(duty_cycle), 63);
      wait_tick(); check("odd_dn_62", int'(duty_cycle), 62);
      send(80);
      send(40);
      check("b2b_duty", int'(duty_cycle), 62);
      check("b2b_ready", int'(target_ready), 0);
      check("b2b_busy", int'(busy), 1);
      wait_tick(); check("b2b_64", int'(duty_cycle), 64);
      wait_tick(); check("b2b_rev_62", int'(duty_cycle), 62);
      n = 0;
      while (busy && n < 60) begin wait_tick(); n++; end
      check("b2b_final_40", int'(duty_cycle), 40);
      send(62); settle();
      send(70); wait_tick();
      wait_tick(); wait_tick(); wait_tick();
      check("pre_reset_68", int'(duty_cycle), 68);
      send(90);
      #2 reset = 0;
      #1;
      check("async_duty", int'(duty_cycle), 62);
      check("async_busy", int'(busy), 0);
      check("async_ready", int'(target_ready), 1);
      check("async_at", int'(at_target), 1);
      check("async_tick", int'(frame_tick), 0);
      @(negedge clk);
      #2 reset = 1;
      repeat (30) @(negedge clk);
      check("discarded_pending", int'(duty_cycle), 62);
`ifdef SERVO_IDLE_RELEASE_EN
      #2 reset = 0;
      #2 reset = 1;
      wait_tick(); wait_tick();
      check("release_not_yet", int'(pwm_enable), 1);
      wait_tick();
      check("release_after_3", int'(pwm_enable), 0);
      send(70);
      check("release_reenable", int'(pwm_enable), 1);
      settle();
`endif
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
